gt_victim_cache: RTL and testbench
==================================

Name: gt_victim_cache

Overview:
- Fully-associative victim cache on the eviction side of the 32-line direct-mapped L1.
- Accepts lines the L1 evicts when it refills a set.
- Answers L1 miss lookups and returns the matching 256-bit line on a hit; that line then moves back into L1 (swap semantics).
- Sits between the L1 and main memory; its returned line feeds the L1 refill-from-victim input.

Parameters:
- DEPTH, 4, number of victim entries; power of two, ≥2.
- PTR_W, 2, log2(DEPTH); width of the FIFO replacement pointer.
- CNT_W, 16, width of the saturating hit/miss statistics counters.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  1  L1 miss lookup request, single-cycle pulse per request.
- req_addr  in  32  byte address of the lookup; line tag = req_addr[31:5].
- evict_valid  in  1  L1 is evicting a line this cycle.
- evict_tag  in  27  line tag of the evicted line (address[31:5]).
- evict_data  in  256  evicted line data.
- resp_valid  out  1  lookup response strobe, one cycle.
- resp_hit  out  1  lookup hit, qualified by resp_valid.
- resp_data  out  256  returned line on hit; all-zero on miss.
- occupancy  out  PTR_W+1  number of valid entries.
- hit_count  out  CNT_W  lookup hits since reset, saturating.
- miss_count  out  CNT_W  lookup misses since reset, saturating.

Behaviour:
- Reset (synchronous, active-high):
  - All entry valid bits clear; FIFO pointer = 0.
  - resp_valid = 0, resp_hit = 0, resp_data = 0.
  - occupancy = 0, hit_count = 0, miss_count = 0.
  - Entry tag/data contents are don't-care.
- Reset mid-operation: a lookup presented in the reset cycle is dropped (no response). An eviction presented in the reset cycle is not stored.
- Storage per entry: valid (1), tag (27), data (256).
- Lookup latency:
  - req_valid sampled at edge N; tag compared against all valid entries in the cycle before edge N.
  - resp_valid, resp_hit and resp_data are registered and appear after edge N, for exactly one cycle.
  - Back-to-back requests are accepted every cycle; there is no stall or ready signal.
- Lookup hit on entry k:
  - resp_hit = 1, resp_data = entry k data.
  - Entry k valid is cleared at the same edge, unless an eviction is written into k (see below).
  - hit_count += 1, saturating at all-ones.
- Lookup miss: resp_hit = 0, resp_data = 0; miss_count += 1, saturating at all-ones.
- At most one entry can match: duplicate tags are prevented by insertion rule 1.
- Eviction insert (evict_valid at an edge). Slot selection in priority order:
  1. A valid entry whose tag == evict_tag: overwrite its data in place; pointer unchanged.
  2. The slot freed by a same-cycle lookup hit k: write into k, keep valid = 1; pointer unchanged.
  3. Lowest-index invalid entry: write and set valid; pointer unchanged.
  4. Cache full: replace the entry at the FIFO pointer; pointer = (pointer+1) mod DEPTH. The displaced line is dropped; L1 lines are clean, so no write-back is needed.
- Same-cycle eviction and lookup on the same tag: the response returns the pre-write data (read-before-write). The entry then holds evict_data with valid = 1.
- No bypass: a lookup never sees an eviction presented in the same cycle.
- occupancy is registered and reflects the state after each edge:
  - hit only: −1.
  - insert into an invalid slot: +1.
  - swap, overwrite, or FIFO replace: unchanged.
- Address bits [4:0] of req_addr are ignored; byte selection is done by L1.

Test Plan:
- Reset, then req_valid with req_addr=0x0000_1040 -> next cycle resp_valid=1, resp_hit=0, resp_data=0, miss_count=1, occupancy=0.
- Evict tag 0x0000082 with data {8{32'hDEADBEEF}}, then lookup addr 0x0000_105F -> resp_hit=1 with that data. Occupancy goes 1 -> 0. A repeat lookup of the same address misses.
- Evict tags 1,2,3,4,5 on consecutive cycles with DEPTH=4 -> occupancy saturates at 4 and tag 1 is replaced (pointer 0 -> 1). Lookup of tag 1 misses; lookups of tags 2-5 hit.
- Full cache holding tags 2-5: same-cycle lookup of tag 3 and evict of tag 9 -> resp_data = tag-3 data, tag 9 stored in tag 3's slot, occupancy stays 4, pointer unchanged.
- Evict tag 7 with data A, then tag 7 with data B -> occupancy=1; lookup of tag 7 returns B.
- Assert RST in the same cycle as req_valid and evict_valid -> no response pulse follows, occupancy=0, counters=0.

Source files
------------

// File: rtl/gt_victim_cache.sv
// Fully-associative victim cache behind the direct-mapped L1: holds evicted lines,
// answers L1 miss lookups one cycle later and hands a hit line back (swap semantics).
module gt_victim_cache #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               req_valid,
  input  logic [31:0]        req_addr,
  input  logic               evict_valid,
  input  logic [26:0]        evict_tag,
  input  logic [255:0]       evict_data,
  output logic               resp_valid,
  output logic               resp_hit,
  output logic [255:0]       resp_data,
  output logic [PTR_W:0]     occupancy,
  output logic [CNT_W-1:0]   hit_count,
  output logic [CNT_W-1:0]   miss_count
);

  localparam int unsigned TAG_W  = 27;
  localparam int unsigned DATA_W = 256;
  localparam int unsigned OCC_W  = PTR_W + 1;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;

  logic              resp_valid_q, resp_valid_d;
  logic              resp_hit_q, resp_hit_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]  req_tag;
  logic              hit_any, match_any, free_any, lookup_hit;
  logic [PTR_W-1:0]  hit_idx, match_idx, free_idx, wr_idx;

  // Byte offset within the line is resolved by the L1.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[4:0];

  // Tag search, slot selection and next-state computation
  always_comb begin
    req_tag      = req_addr[31:5];
    hit_any      = 1'b0;
    hit_idx      = '0;
    match_any    = 1'b0;
    match_idx    = '0;
    free_any     = 1'b0;
    free_idx     = '0;
    wr_idx       = ptr_q;
    ptr_d        = ptr_q;
    valid_d      = valid_q;
    occ_d        = '0;
    resp_valid_d = req_valid;
    resp_hit_d   = 1'b0;
    resp_data_d  = '0;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;

    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && tag_q[i] == req_tag) begin
        hit_any = 1'b1;
        hit_idx = PTR_W'(i);
      end
      if (valid_q[i] && tag_q[i] == evict_tag) begin
        match_any = 1'b1;
        match_idx = PTR_W'(i);
      end
    end
    // Descending scan leaves the lowest-index free slot selected
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = PTR_W'(i);
      end
    end

    lookup_hit = req_valid && hit_any;

    if (match_any)       wr_idx = match_idx;
    else if (lookup_hit) wr_idx = hit_idx;
    else if (free_any)   wr_idx = free_idx;
    else                 wr_idx = ptr_q;

    if (evict_valid && !match_any && !lookup_hit && !free_any)
      ptr_d = ptr_q + PTR_W'(1);

    if (lookup_hit)  valid_d[hit_idx] = 1'b0;
    if (evict_valid) valid_d[wr_idx]  = 1'b1;

    for (int i = 0; i < int'(DEPTH); i++)
      occ_d = occ_d + OCC_W'(valid_d[i]);

    if (lookup_hit) begin
      resp_hit_d  = 1'b1;
      resp_data_d = data_q[hit_idx];
      if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end else if (req_valid) begin
      if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  // State and registered outputs; tag/data storage needs no reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q      <= '0;
      ptr_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_data_q  <= '0;
      occ_q        <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      ptr_q        <= ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_data_q  <= resp_data_d;
      occ_q        <= occ_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      if (evict_valid) begin
        tag_q[wr_idx]  <= evict_tag;
        data_q[wr_idx] <= evict_data;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_data  = resp_data_q;
  assign occupancy  = occ_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_gt_victim_cache.sv
// Directed bench for gt_victim_cache: expected lookup responses are queued at issue
// and matched when the response strobe appears; state outputs checked after each step.
module tb_gt_victim_cache;

  logic         CLK;
  logic         RST;
  logic         req_valid;
  logic [31:0]  req_addr;
  logic         evict_valid;
  logic [26:0]  evict_tag;
  logic [255:0] evict_data;
  logic         resp_valid;
  logic         resp_hit;
  logic [255:0] resp_data;
  logic [2:0]   occupancy;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  int checks = 0;
  int errors = 0;
  logic [256:0] sb [$];

  gt_victim_cache #(.DEPTH(4), .PTR_W(2), .CNT_W(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .evict_valid(evict_valid),
    .evict_tag  (evict_tag),
    .evict_data (evict_data),
    .resp_valid (resp_valid),
    .resp_hit   (resp_hit),
    .resp_data  (resp_data),
    .occupancy  (occupancy),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] dat(input logic [26:0] tag);
    return {8{tag, 5'h15}};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic lookup(input logic [31:0] addr, input logic hit, input logic [255:0] data);
    req_valid = 1'b1;
    req_addr  = addr;
    sb.push_back({hit, data});
    tick();
    req_valid = 1'b0;
  endtask

  task automatic evict(input logic [26:0] tag, input logic [255:0] data);
    evict_valid = 1'b1;
    evict_tag   = tag;
    evict_data  = data;
    tick();
    evict_valid = 1'b0;
  endtask

  task automatic both(input logic [26:0] ltag, input logic hit, input logic [255:0] rdata,
                      input logic [26:0] etag, input logic [255:0] edata);
    req_valid   = 1'b1;
    req_addr    = {ltag, 5'h0};
    evict_valid = 1'b1;
    evict_tag   = etag;
    evict_data  = edata;
    sb.push_back({hit, rdata});
    tick();
    req_valid   = 1'b0;
    evict_valid = 1'b0;
  endtask

  task automatic state(input string tag, input int occ, input int hits, input int misses);
    chk({tag, "_occ"},  256'(occupancy),  256'(occ));
    chk({tag, "_hits"}, 256'(hit_count),  256'(hits));
    chk({tag, "_miss"}, 256'(miss_count), 256'(misses));
  endtask

  // Response scoreboard: every strobe must match the oldest queued expectation
  always @(negedge CLK) begin
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 256'(resp_valid), 256'(0));
      end else begin
        logic [256:0] e;
        e = sb.pop_front();
        chk("resp_hit",  256'(resp_hit), 256'(e[256]));
        chk("resp_data", resp_data,      e[255:0]);
      end
    end
  end

  initial begin
    RST = 1'b1; req_valid = 1'b0; req_addr = '0;
    evict_valid = 1'b0; evict_tag = '0; evict_data = '0;
    tick(); tick();
    RST = 1'b0;
    chk("reset_resp_valid", 256'(resp_valid), 256'(0));
    chk("reset_resp_data", resp_data, 256'(0));
    state("reset", 0, 0, 0);

    // Miss on empty cache
    lookup(32'h0000_1040, 1'b0, 256'(0));
    state("first_miss", 0, 0, 1);

    // Single insert, hit with offset bits set, then repeat misses
    evict(27'h0000082, {8{32'hDEADBEEF}});
    chk("insert_occ", 256'(occupancy), 256'(1));
    lookup(32'h0000_105F, 1'b1, {8{32'hDEADBEEF}});
    state("swap_hit", 0, 1, 1);
    lookup(32'h0000_105F, 1'b0, 256'(0));
    state("repeat_miss", 0, 1, 2);

    // Fill beyond depth: tag 1 displaced by FIFO (slot0), pointer moves to 1
    for (int t = 1; t <= 5; t++) evict(27'(t), dat(27'(t)));
    chk("full_occ", 256'(occupancy), 256'(4));
    lookup({27'd1, 5'h0}, 1'b0, 256'(0));
    state("fifo_victim", 4, 1, 3);

    // Swap on full cache: tag 9 lands in tag 3's slot, pointer untouched
    both(27'd3, 1'b1, dat(27'd3), 27'd9, dat(27'd9));
    state("full_swap", 4, 2, 3);
    // Pointer still 1: tag 10 displaces tag 2 (slot1), not tag 5 (slot0)
    evict(27'd10, dat(27'd10));
    chk("replace_occ", 256'(occupancy), 256'(4));
    lookup({27'd2, 5'h0}, 1'b0, 256'(0));
    lookup({27'd4, 5'h0}, 1'b1, dat(27'd4));
    lookup({27'd5, 5'h0}, 1'b1, dat(27'd5));
    lookup({27'd9, 5'h0}, 1'b1, dat(27'd9));
    lookup({27'd10, 5'h0}, 1'b1, dat(27'd10));
    state("drain", 0, 6, 4);

    // Overwrite in place
    evict(27'd7, {8{32'hAAAA_0007}});
    evict(27'd7, {8{32'hBBBB_0007}});
    chk("overwrite_occ", 256'(occupancy), 256'(1));
    lookup({27'd7, 5'h0}, 1'b1, {8{32'hBBBB_0007}});
    state("overwrite_hit", 0, 7, 4);

    // Same-tag lookup and eviction: old data returned, new data kept
    evict(27'd6, {8{32'hCCCC_0006}});
    both(27'd6, 1'b1, {8{32'hCCCC_0006}}, 27'd6, {8{32'hDDDD_0006}});
    state("rbw", 1, 8, 4);
    lookup({27'd6, 5'h0}, 1'b1, {8{32'hDDDD_0006}});
    // No bypass of a same-cycle eviction
    both(27'd8, 1'b0, 256'(0), 27'd8, dat(27'd8));
    state("no_bypass", 1, 9, 5);
    lookup({27'd8, 5'h0}, 1'b1, dat(27'd8));
    state("after_bypass", 0, 10, 5);

    // Reset mid-operation drops both the lookup and the eviction
    evict(27'd11, dat(27'd11));
    RST = 1'b1; req_valid = 1'b1; req_addr = {27'd11, 5'h0};
    evict_valid = 1'b1; evict_tag = 27'd12; evict_data = dat(27'd12);
    tick();
    RST = 1'b0; req_valid = 1'b0; evict_valid = 1'b0;
    state("mid_reset", 0, 0, 0);
    chk("mid_reset_resp", 256'(resp_valid), 256'(0));
    tick();
    chk("mid_reset_no_pulse", 256'(resp_valid), 256'(0));
    lookup({27'd11, 5'h0}, 1'b0, 256'(0));
    lookup({27'd12, 5'h0}, 1'b0, 256'(0));
    state("post_reset", 0, 0, 2);

    tick(); tick();
    chk("scoreboard_drained", 256'(sb.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
